// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 windows (stride 2) for the pooling stage.
// Optional status outputs (frame_done, win_count) are enabled by defining POOL_WIN_STATUS_EN.
module pool_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic signed [DATA_W-1:0] window0,
    output logic signed [DATA_W-1:0] window1,
    output logic signed [DATA_W-1:0] window2,
    output logic signed [DATA_W-1:0] window3
`ifdef POOL_WIN_STATUS_EN
    ,
    output logic                     frame_done,
    output logic [15:0]              win_count
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {
        ST_TOP,
        ST_BOT
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic                       win_valid_q, win_valid_d;
    logic                       last_win_q, last_win_d;
    logic signed [DATA_W-1:0]   win0_q, win0_d;
    logic signed [DATA_W-1:0]   win1_q, win1_d;
    logic signed [DATA_W-1:0]   win2_q, win2_d;
    logic signed [DATA_W-1:0]   win3_q, win3_d;
    logic signed [DATA_W-1:0]   bl_reg_q, bl_reg_d;
    logic signed [DATA_W-1:0]   linebuf_q [IMG_W];

    logic          accept;
    logic          handshake;
    logic          col_last;
    logic          row_last;
    logic          lb_we;
    logic [CW-1:0] col_pair;

    assign in_ready  = !win_valid_q || win_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = win_valid_q && win_ready;
    assign col_last  = (col_q == CW'(IMG_W - 1));
    assign row_last  = (row_q == RW'(IMG_H - 1));
    // Even column of the current pair: left-hand linebuf entry of the window.
    assign col_pair  = col_q & ~CW'(1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        last_win_d  = last_win_q;
        win0_d      = win0_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        win3_d      = win3_q;
        bl_reg_d    = bl_reg_q;
        lb_we       = 1'b0;

        if (handshake) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d   = row_last ? '0 : row_q + RW'(1);
                state_d = (state_q == ST_TOP) ? ST_BOT : ST_TOP;
            end

            if (state_q == ST_TOP) begin
                lb_we = 1'b1;
            end else if (!col_q[0]) begin
                bl_reg_d = in_pixel;
            end else begin
                // Completing beat: a load here wins over the handshake clear above.
                win0_d      = linebuf_q[col_pair];
                win1_d      = linebuf_q[col_q];
                win2_d      = bl_reg_q;
                win3_d      = in_pixel;
                win_valid_d = 1'b1;
                last_win_d  = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TOP;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            last_win_q  <= 1'b0;
            win0_q      <= '0;
            win1_q      <= '0;
            win2_q      <= '0;
            win3_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            last_win_q  <= last_win_d;
            win0_q      <= win0_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            win3_q      <= win3_d;
        end
    end

    // Line buffer and held bottom-left pixel carry no reset; stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[col_q] <= in_pixel;
        end
        bl_reg_q <= bl_reg_d;
    end

    assign win_valid = win_valid_q;
    assign window0   = win0_q;
    assign window1   = win1_q;
    assign window2   = win2_q;
    assign window3   = win3_q;

`ifdef POOL_WIN_STATUS_EN
    logic        frame_done_q, frame_done_d;
    logic [15:0] win_count_q, win_count_d;

    // The count shows the full frame total during the frame_done cycle, then restarts.
    always_comb begin
        frame_done_d = handshake && last_win_q;
        win_count_d  = win_count_q;
        if (frame_done_q) begin
            win_count_d = handshake ? 16'd1 : 16'd0;
        end else if (handshake) begin
            win_count_d = win_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            win_count_q  <= '0;
        end else begin
            frame_done_q <= frame_done_d;
            win_count_q  <= win_count_d;
        end
    end

    assign frame_done = frame_done_q;
    assign win_count  = win_count_q;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen: directed 4x4 frames on one instance, 2x2 signed frame on another.
module tb_pool_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic               in_valid, in_ready, win_valid, win_ready;
    logic signed [15:0] in_pixel, w0, w1, w2, w3;
    logic               in_valid2, in_ready2, win_valid2, win_ready2;
    logic signed [15:0] in_pixel2, v0, v1, v2, v3;
`ifdef POOL_WIN_STATUS_EN
    logic               fd, fd2;
    logic [15:0]        wc, wc2;
`endif

    pool_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .win_valid(win_valid), .win_ready(win_ready),
        .window0(w0), .window1(w1), .window2(w2), .window3(w3)
`ifdef POOL_WIN_STATUS_EN
        , .frame_done(fd), .win_count(wc)
`endif
    );

    pool_window_gen #(.DATA_W(16), .IMG_W(2), .IMG_H(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_pixel(in_pixel2),
        .win_valid(win_valid2), .win_ready(win_ready2),
        .window0(v0), .window1(v1), .window2(v2), .window3(v3)
`ifdef POOL_WIN_STATUS_EN
        , .frame_done(fd2), .win_count(wc2)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fd_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp2_q[$];
    int          lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    logic prev_v  = 1'b0;
    logic prev_hs = 1'b0;

    always @(negedge clk) begin
        #2;
        if (win_valid && (!prev_v || prev_hs)) begin
            if (lat_q.size() == 0) flag_fail("win_latency: window appeared with no completing pixel");
            else check("win_latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
        if (!rst && win_valid && win_ready) begin
            if (exp_q.size() == 0) flag_fail("extra_window: handshake with empty scoreboard");
            else check("window", {w0, w1, w2, w3}, exp_q.pop_front());
        end
        prev_v  = win_valid && !rst;
        prev_hs = win_valid && win_ready && !rst;
`ifdef POOL_WIN_STATUS_EN
        if (!rst && fd) begin
            fd_cnt++;
            check("win_count_at_done", 64'(wc), 64'd4);
        end
`endif
    end

    always @(negedge clk) begin
        #2;
        if (!rst && win_valid2 && win_ready2) begin
            if (exp2_q.size() == 0) flag_fail("extra_window2: handshake with empty scoreboard");
            else check("window_2x2", {v0, v1, v2, v3}, exp2_q.pop_front());
        end
    end

    task automatic drive(input logic [15:0] p, input bit fourth);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_pixel = p;
        #1;
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                flag_fail("drive_timeout: in_ready stuck at 0");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        if (fourth) lat_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drive2(input logic [15:0] p);
        int n;
        n         = 0;
        in_valid2 = 1'b1;
        in_pixel2 = p;
        #1;
        while (!in_ready2) begin
            n++;
            if (n > 200) begin
                flag_fail("drive2_timeout: in_ready stuck at 0");
                in_valid2 = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        in_valid2 = 1'b0;
    endtask

    task automatic frame4(input bit bubbles);
        for (int i = 0; i < 16; i++) begin
            drive(16'h0400 + 16'(i), ((i / 4) % 2 == 1) && (i % 2 == 1));
            if (bubbles) @(negedge clk);
        end
    endtask

    task automatic push_test1_windows();
        exp_q.push_back(64'h0400_0401_0404_0405);
        exp_q.push_back(64'h0402_0403_0406_0407);
        exp_q.push_back(64'h0408_0409_040C_040D);
        exp_q.push_back(64'h040A_040B_040E_040F);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            flag_fail({name, "_drain: expected windows never emitted"});
            exp_q.delete();
            exp2_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        #1;
        check({name, "_win_valid"}, 64'(win_valid), 64'd0);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        check({name, "_window"}, {w0, w1, w2, w3}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pixel   = '0;
        win_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_pixel2  = '0;
        win_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // 4x4 frame, continuous input
        push_test1_windows();
        frame4(1'b0);
        drain("t1");

        // Signed data through a 2x2 frame
        exp2_q.push_back(64'hFC00_F000_8400_0700);
        drive2(16'hFC00);
        drive2(16'hF000);
        drive2(16'h8400);
        drive2(16'h0700);
        drain("t2");

        // Backpressure on the first window
        push_test1_windows();
        fork
            frame4(1'b0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!win_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                win_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_window_hold", {w0, w1, w2, w3}, 64'h0400_0401_0404_0405);
                    @(negedge clk);
                end
                win_ready = 1'b1;
            end
        join
        drain("t3");

        // Bubbles on every other cycle
        push_test1_windows();
        frame4(1'b1);
        drain("t4");

        // Reset after 6 pixels; the partial window is never consumed
        win_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(16'h0400 + 16'(i), (i == 5));
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        check_reset_state("midreset");
        win_ready = 1'b1;
        push_test1_windows();
        frame4(1'b0);
        drain("t5");

        // Two back-to-back frames
        fd_cnt = 0;
        push_test1_windows();
        push_test1_windows();
        frame4(1'b0);
        frame4(1'b0);
        drain("t6");
`ifdef POOL_WIN_STATUS_EN
        check("frame_done_pulses", 64'(fd_cnt), 64'd2);
`endif
        check("lat_queue_empty", 64'(lat_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
